// File: rtl/uart_arb_pkg.sv
// Shared types, defaults and width helper for the UART transmit arbiter.
package uart_arb_pkg;

   localparam int unsigned DEF_NUM_REQ  = 4;
   localparam int unsigned DEF_DATA_LEN = 8;
   localparam int unsigned DEF_TIMEOUT  = 32768;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

   // Bits needed to index n items; never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after the pointer.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]             i_req,
   input  logic [width_of(NUM_REQ)-1:0]   i_ptr,
   output logic                           o_valid,
   output logic [width_of(NUM_REQ)-1:0]   o_grant
);

   localparam int unsigned IdW = width_of(NUM_REQ);

   logic [IdW-1:0] w_sel;

   // Scan pointer+1 .. pointer+NUM_REQ so the last winner is considered last.
   always_comb begin
      o_valid = 1'b0;
      o_grant = '0;
      w_sel   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_sel = IdW'((32'(i_ptr) + k) % NUM_REQ);
         if (!o_valid && i_req[w_sel]) begin
            o_valid = 1'b1;
            o_grant = w_sel;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ requesters with round-robin
// priority and a watchdog that aborts a transfer whose tx_done never comes.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter int unsigned DATA_LEN = DEF_DATA_LEN,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*DATA_LEN-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]            o_ack,
   output logic                          o_err_timeout,
   output logic [width_of(NUM_REQ)-1:0]  o_grant_id,
   output logic                          o_busy,
   output logic                          o_uart_send,
   output logic [DATA_LEN-1:0]           o_uart_data,
   input  logic                          i_uart_busy,
   input  logic                          i_uart_done
);

   localparam int unsigned IdW = width_of(NUM_REQ);
   localparam int unsigned WdW = width_of(TIMEOUT);
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

   arb_state_t          r_state, w_state_nxt;
   logic [IdW-1:0]      r_grant, w_grant_nxt;
   logic [IdW-1:0]      r_ptr, w_ptr_nxt;
   logic [DATA_LEN-1:0] r_data, w_data_nxt;
   logic                r_send, w_send_nxt;
   logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
   logic                r_err, w_err_nxt;
   logic [WdW-1:0]      r_wd, w_wd_nxt;

   logic                w_valid;
   logic [IdW-1:0]      w_win;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_valid (w_valid),
      .o_grant (w_win)
   );

   // Next-state and registered-output decode for the IDLE/WAIT/ACK sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      w_data_nxt  = r_data;
      w_send_nxt  = 1'b0;
      w_ack_nxt   = '0;
      w_err_nxt   = 1'b0;
      w_wd_nxt    = r_wd;
      unique case (r_state)
         IDLE: begin
            if (w_valid && !i_uart_busy) begin
               w_grant_nxt = w_win;
               w_data_nxt  = i_req_data[32'(w_win)*DATA_LEN +: DATA_LEN];
               w_send_nxt  = 1'b1;
               w_wd_nxt    = '0;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            // The launch cycle itself is not counted, so an abort lands
            // TIMEOUT+1 cycles after the send pulse.
            if (!r_send) begin
               w_wd_nxt = r_wd + 1'b1;
            end
            if (i_uart_done) begin
               w_ack_nxt[r_grant] = 1'b1;
               w_state_nxt        = ACK;
            end else if (r_wd == WdLast) begin
               w_ack_nxt[r_grant] = 1'b1;
               w_err_nxt          = 1'b1;
               w_state_nxt        = ACK;
            end
         end
         ACK: begin
            w_ptr_nxt   = r_grant;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, watchdog and output registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= IdW'(NUM_REQ - 1);
         r_data  <= '0;
         r_send  <= 1'b0;
         r_ack   <= '0;
         r_err   <= 1'b0;
         r_wd    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
         r_data  <= w_data_nxt;
         r_send  <= w_send_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_wd    <= w_wd_nxt;
      end
   end

   assign o_ack         = r_ack;
   assign o_err_timeout = r_err;
   assign o_grant_id    = r_grant;
   assign o_busy        = (r_state != IDLE);
   assign o_uart_send   = r_send;
   assign o_uart_data   = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench: arbiter driving a behavioural 8N1 transmitter (4 clocks per bit),
// plus a second arbiter with TIMEOUT=16 whose tx_done never arrives.
module tb_uart_tx_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic       err;
   } ack_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic        err;
   logic [1:0]  gid;
   logic        busy;
   logic        usend;
   logic [7:0]  udata;
   logic        tx_busy, tx_done, line, force_busy, uart_busy;

   logic [3:0]  wd_req;
   logic [31:0] wd_data;
   logic [3:0]  wd_ack;
   logic        wd_err, wd_busy, wd_send;
   logic [1:0]  wd_gid;
   logic [7:0]  wd_udata;

   assign uart_busy = tx_busy | force_busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_LEN(8), .TIMEOUT(200)) u_dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_req         (req),
      .i_req_data    (req_data),
      .o_ack         (ack),
      .o_err_timeout (err),
      .o_grant_id    (gid),
      .o_busy        (busy),
      .o_uart_send   (usend),
      .o_uart_data   (udata),
      .i_uart_busy   (uart_busy),
      .i_uart_done   (tx_done)
   );

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_LEN(8), .TIMEOUT(16)) u_dut_wd (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_req         (wd_req),
      .i_req_data    (wd_data),
      .o_ack         (wd_ack),
      .o_err_timeout (wd_err),
      .o_grant_id    (wd_gid),
      .o_busy        (wd_busy),
      .o_uart_send   (wd_send),
      .o_uart_data   (wd_udata),
      .i_uart_busy   (1'b0),
      .i_uart_done   (1'b0)
   );

   // Transmitter model: start bit, 8 data bits LSB first, stop bit, then tx_done.
   logic [1:0] tx_cnt;
   logic [3:0] tx_bit;
   logic [9:0] tx_sh;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_busy <= 1'b0; tx_done <= 1'b0; line <= 1'b1;
         tx_cnt <= '0; tx_bit <= '0; tx_sh <= '1;
      end else begin
         tx_done <= 1'b0;
         if (!tx_busy) begin
            if (usend) begin
               tx_busy <= 1'b1; tx_sh <= {1'b1, udata, 1'b0};
               tx_cnt <= '0; tx_bit <= '0; line <= 1'b0;
            end
         end else if (tx_cnt == 2'd3) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
               tx_busy <= 1'b0; tx_done <= 1'b1; line <= 1'b1;
            end else begin
               tx_bit <= tx_bit + 4'd1;
               line   <= tx_sh[tx_bit + 4'd1];
            end
         end else begin
            tx_cnt <= tx_cnt + 2'd1;
         end
      end
   end

   // Line receiver: detects the start bit and samples each bit near its middle.
   logic       rx_act, rx_valid, rx_stop;
   logic [5:0] rx_c;
   logic [7:0] rx_sh, rx_byte;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_act <= 1'b0; rx_valid <= 1'b0; rx_stop <= 1'b0;
         rx_c <= '0; rx_sh <= '0; rx_byte <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (!rx_act) begin
            if (!line) begin
               rx_act <= 1'b1; rx_c <= 6'd1;
            end
         end else begin
            rx_c <= rx_c + 6'd1;
            if (rx_c >= 6'd5 && rx_c <= 6'd33 && rx_c[1:0] == 2'b01) begin
               rx_sh <= {line, rx_sh[7:1]};
            end
            if (rx_c == 6'd37) begin
               rx_byte <= rx_sh; rx_stop <= line; rx_valid <= 1'b1; rx_act <= 1'b0;
            end
         end
      end
   end

   int       n_checks, n_errors;
   int       cyc, done_cyc, send_cyc, ack_cyc, n_sends, n_acks;
   int       wd_send_cyc, wd_ack_cyc;
   bit       prev_send, gap_armed, chk_gap, wd_seen;
   int       left [4];
   int       sent [4];
   logic [7:0] base [4];
   ack_exp_t q_ack [$];
   logic [7:0] q_rx [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void drive_reqs();
      for (int i = 0; i < 4; i++) begin
         req[i] = (left[i] > 0);
         req_data[i*8 +: 8] = base[i] + 8'(sent[i]);
      end
   endfunction

   function automatic void push_exp(input int id, input logic [7:0] b);
      ack_exp_t e;
      e.id  = 2'(id);
      e.err = 1'b0;
      q_ack.push_back(e);
      q_rx.push_back(b);
   endfunction

   // One clock: sample outputs just after the edge, score them, update requesters.
   task automatic tick();
      ack_exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
         if (tx_done) done_cyc = cyc;
         if (usend) begin
            check_eq("send_single_cycle", 32'(prev_send), 0);
            check_eq("busy_on_send", 32'(busy), 1);
            n_sends++;
            send_cyc = cyc;
            if (chk_gap && gap_armed) check_eq("rearb_gap", cyc - ack_cyc, 2);
            gap_armed = 1'b0;
         end
         if (ack != 4'b0) begin
            n_acks++;
            ack_cyc   = cyc;
            gap_armed = 1'b1;
            if (q_ack.size() == 0) begin
               check_eq("ack_unexpected", q_ack.size(), 1);
            end else begin
               e = q_ack.pop_front();
               check_eq("ack_onehot", 32'(ack), 32'(1) << e.id);
               check_eq("ack_grant_id", 32'(gid), 32'(e.id));
               check_eq("ack_err", 32'(err), 32'(e.err));
               check_eq("ack_after_done", cyc - done_cyc, 1);
            end
            for (int i = 0; i < 4; i++) begin
               if (ack[i] && left[i] > 0) begin
                  left[i]--;
                  sent[i]++;
               end
            end
         end
         if (rx_valid) begin
            if (q_rx.size() == 0) begin
               check_eq("rx_unexpected", q_rx.size(), 1);
            end else begin
               check_eq("line_byte", 32'(rx_byte), 32'(q_rx.pop_front()));
               check_eq("line_stop", 32'(rx_stop), 1);
            end
         end
         if (wd_send) wd_send_cyc = cyc;
         if (wd_ack != 4'b0) begin
            wd_ack_cyc = cyc;
            wd_seen    = 1'b1;
         end
         prev_send = usend;
      end
      drive_reqs();
   endtask

   task automatic wait_acks(input int n, input int budget);
      int start;
      start = n_acks;
      for (int k = 0; k < budget && (n_acks - start) < n; k++) tick();
      check_eq("acks_within_budget", n_acks - start, n);
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < 4; i++) begin
         left[i] = 0; sent[i] = 0; base[i] = 8'h00;
      end
      q_ack.delete();
      q_rx.delete();
      wd_req = '0; wd_data = '0; force_busy = 1'b0;
      gap_armed = 1'b0; prev_send = 1'b0; chk_gap = 1'b0;
      drive_reqs();
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_busy"}, 32'(busy), 0);
      check_eq({pfx, "_send"}, 32'(usend), 0);
      check_eq({pfx, "_ack"}, 32'(ack), 0);
      check_eq({pfx, "_err"}, 32'(err), 0);
      check_eq({pfx, "_gid"}, 32'(gid), 0);
      check_eq({pfx, "_data"}, 32'(udata), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_reqs();
      repeat (2) tick();
      check_reset_outputs("rst");
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int c0;
      n_checks = 0; n_errors = 0; cyc = 0; n_sends = 0; n_acks = 0;
      done_cyc = 0; send_cyc = 0; ack_cyc = 0; wd_send_cyc = 0; wd_ack_cyc = 0;
      wd_seen = 1'b0;
      reset = 1'b1;
      clear_reqs();

      // Single byte from requester 1.
      do_reset();
      base[1] = 8'hA5; left[1] = 1;
      push_exp(1, 8'hA5);
      drive_reqs();
      wait_acks(1, 100);

      // Simultaneous requests 0 and 2: requester 0 goes first.
      do_reset();
      base[0] = 8'h11; base[2] = 8'h22; left[0] = 1; left[2] = 1;
      push_exp(0, 8'h11);
      push_exp(2, 8'h22);
      drive_reqs();
      wait_acks(2, 200);

      // Fairness: all four held for two bytes each; back-to-back re-arbitration.
      do_reset();
      chk_gap = 1'b1;
      for (int i = 0; i < 4; i++) begin
         base[i] = 8'h40 + 8'(i * 16);
         left[i] = 2;
      end
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) push_exp(i, 8'h40 + 8'(i * 16) + 8'(r));
      end
      drive_reqs();
      wait_acks(8, 600);
      chk_gap = 1'b0;

      // Watchdog abort on the TIMEOUT=16 instance.
      do_reset();
      wd_seen = 1'b0;
      wd_req  = 4'b0001;
      wd_data = 32'h0000_005A;
      for (int k = 0; k < 40 && !wd_seen; k++) tick();
      check_eq("wd_ack_seen", 32'(wd_seen), 1);
      check_eq("wd_latency", wd_ack_cyc - wd_send_cyc, 17);
      check_eq("wd_ack", 32'(wd_ack), 32'h1);
      check_eq("wd_err", 32'(wd_err), 1);
      check_eq("wd_data", 32'(wd_udata), 32'h5A);
      wd_req = '0;
      tick();
      check_eq("wd_idle_after", 32'(wd_busy), 0);
      check_eq("wd_err_pulse", 32'(wd_err), 0);
      check_eq("wd_ack_pulse", 32'(wd_ack), 0);

      // Busy hold: no launch while the transmitter reports busy.
      do_reset();
      force_busy = 1'b1;
      base[3] = 8'h3C; left[3] = 1;
      push_exp(3, 8'h3C);
      drive_reqs();
      c0 = n_sends;
      repeat (10) tick();
      check_eq("hold_no_send", n_sends - c0, 0);
      check_eq("hold_idle", 32'(busy), 0);
      force_busy = 1'b0;
      tick();
      check_eq("send_after_busy", 32'(usend), 1);
      wait_acks(1, 100);

      // Reset mid-WAIT during data bit 3, then pointer restarts at requester 0.
      do_reset();
      base[1] = 8'h96; left[1] = 1;
      drive_reqs();
      for (int k = 0; k < 10 && !usend; k++) tick();
      check_eq("mid_send_seen", 32'(usend), 1);
      repeat (18) tick();
      check_eq("mid_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      clear_reqs();
      base[2] = 8'h21; base[3] = 8'h31; left[2] = 1; left[3] = 1;
      push_exp(2, 8'h21);
      push_exp(3, 8'h31);
      repeat (2) tick();
      reset = 1'b0;
      wait_acks(2, 300);

      check_eq("q_ack_empty", q_ack.size(), 0);
      check_eq("q_rx_empty", q_rx.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
